// File: rtl/thermometer_decoder.sv
// ----------------------------------------------------------------------------
// thermometer_decoder
//   Two-stage pipelined decoder from a sampled TDC thermometer word to a
//   binary fine-time code (code = popcount - 1). Flags raw-input bubbles and
//   the all-zero word. Valid/ready handshake on both sides, one word/cycle.
//
//   Optional feature macro: BUBBLE_CORRECT_EN
//     defined   : stage 1 stores a 3-tap majority-filtered word, removing
//                 single-bit bubbles before the popcount.
//     undefined : stage 1 stores the raw word.
//   bubble_err always reports the raw input in both builds.
// ----------------------------------------------------------------------------
module thermometer_decoder #(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned CODE_W = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [WIDTH-1:0]  therm_in,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [CODE_W-1:0] code_out,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              bubble_err,
   output logic              zero_err
);

   // Popcount needs one extra bit so that an all-ones word (WIDTH) fits.
   localparam int unsigned PC_W = CODE_W + 1;

   // Any 0->1 step going up the raw word (t[i]=0, t[i+1]=1).
   function automatic logic bubble_detect(input logic [WIDTH-1:0] t);
      logic b;
      b = 1'b0;
      for (int unsigned i = 0; i < WIDTH - 1; i++) begin
         b = b | (~t[i] & t[i+1]);
      end
      return b;
   endfunction

   // Word captured by stage 1: majority-filtered or raw.
   function automatic logic [WIDTH-1:0] stage1_word(input logic [WIDTH-1:0] t);
`ifdef BUBBLE_CORRECT_EN
      // Edges are padded so that t[-1]=1 and t[WIDTH]=0; ext[i+1] is t[i].
      logic [WIDTH+1:0] ext;
      logic [WIDTH-1:0] f;
      ext = {1'b0, t, 1'b1};
      f   = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         f[i] = (ext[i]   & ext[i+1]) |
                (ext[i]   & ext[i+2]) |
                (ext[i+1] & ext[i+2]);
      end
      return f;
`else
      return t;
`endif
   endfunction

   // Number of ones in the stored word.
   function automatic logic [PC_W-1:0] popcount(input logic [WIDTH-1:0] t);
      logic [PC_W-1:0] c;
      c = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         c = c + PC_W'(t[i]);
      end
      return c;
   endfunction

   logic             adv;
   logic             s1_valid;
   logic [WIDTH-1:0] s1_therm;
   logic             s1_bub;

   logic [PC_W-1:0]   pc;
   logic [CODE_W-1:0] code_nxt;
   logic              zero_nxt;

   // Pipeline moves whenever the output slot is empty or being drained.
   assign adv      = ~out_valid | out_ready;
   assign in_ready = adv;

   // Stage-2 decode of the stored word.
   always_comb begin
      pc       = popcount(s1_therm);
      code_nxt = '0;
      zero_nxt = 1'b0;
      if (pc == '0) begin
         zero_nxt = 1'b1;
      end else begin
         code_nxt = CODE_W'(pc - PC_W'(1));
      end
   end

   // Stage 1: capture the (optionally filtered) word and the raw bubble flag.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_therm <= '0;
         s1_bub   <= 1'b0;
      end else if (adv) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_therm <= stage1_word(therm_in);
            s1_bub   <= bubble_detect(therm_in);
         end
      end
   end

   // Stage 2: register decoded code and flags; hold them on empty slots.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid  <= 1'b0;
         code_out   <= '0;
         bubble_err <= 1'b0;
         zero_err   <= 1'b0;
      end else if (adv) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            code_out   <= code_nxt;
            zero_err   <= zero_nxt;
            bubble_err <= s1_bub;
         end
      end
   end

endmodule

// File: tb/tb_thermometer_decoder.sv
// ----------------------------------------------------------------------------
// tb_thermometer_decoder
//   Directed, table-driven bench for thermometer_decoder plus hand-written
//   sequences for backpressure and mid-flight reset. Define BUBBLE_CORRECT_EN
//   for both files to exercise the filtered build.
// ----------------------------------------------------------------------------
module tb_thermometer_decoder;

   logic        clk;
   logic        rst_n;
   logic [31:0] therm_in;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  code_out;
   logic        out_valid;
   logic        out_ready;
   logic        bubble_err;
   logic        zero_err;

   int n_checks;
   int n_fail;

   logic [4:0] got[$];
   logic       mon_en;

   typedef struct {
      logic [31:0] therm;
      logic [4:0]  code;
      logic        bub;
      logic        zero;
   } vec_t;

   localparam int NV = 12;
   vec_t vecs[NV];

   thermometer_decoder #(.WIDTH(32), .CODE_W(5)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .therm_in   (therm_in),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .code_out   (code_out),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .bubble_err (bubble_err),
      .zero_err   (zero_err)
   );

   // 10 ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Record every code transferred downstream, sampled after inputs settle.
   always begin
      @(negedge clk);
      #1;
      if (mon_en && out_valid && out_ready) got.push_back(code_out);
   end

   initial begin
      logic accepted;
      n_checks  = 0;
      n_fail    = 0;
      mon_en    = 1'b0;
      rst_n     = 1'b0;
      therm_in  = '0;
      in_valid  = 1'b0;
      out_ready = 1'b1;

      vecs[0]  = '{32'h0000_00FF, 5'd7,  1'b0, 1'b0};
      vecs[1]  = '{32'h0000_0001, 5'd0,  1'b0, 1'b0};
      vecs[2]  = '{32'hFFFF_FFFF, 5'd31, 1'b0, 1'b0};
      vecs[3]  = '{32'h0000_FFFF, 5'd15, 1'b0, 1'b0};
`ifdef BUBBLE_CORRECT_EN
      vecs[4]  = '{32'h0000_00FB, 5'd7,  1'b1, 1'b0};
`else
      vecs[4]  = '{32'h0000_00FB, 5'd6,  1'b1, 1'b0};
`endif
      vecs[5]  = '{32'h0000_0000, 5'd0,  1'b0, 1'b1};
      vecs[6]  = '{32'h0000_0003, 5'd1,  1'b0, 1'b0};
      vecs[7]  = '{32'h7FFF_FFFF, 5'd30, 1'b0, 1'b0};
      vecs[8]  = '{32'h0000_0002, 5'd0,  1'b1, 1'b0};
      vecs[9]  = '{32'h0000_0005, 5'd1,  1'b1, 1'b0};
      vecs[10] = '{32'h0000_0F0F, 5'd7,  1'b1, 1'b0};
`ifdef BUBBLE_CORRECT_EN
      vecs[11] = '{32'h8000_0000, 5'd0,  1'b1, 1'b1};
`else
      vecs[11] = '{32'h8000_0000, 5'd0,  1'b1, 1'b0};
`endif

      // Reset held for three edges.
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid",  32'(out_valid),  32'd0);
      chk("rst_code_out",   32'(code_out),   32'd0);
      chk("rst_bubble_err", 32'(bubble_err), 32'd0);
      chk("rst_zero_err",   32'(zero_err),   32'd0);
      chk("rst_in_ready",   32'(in_ready),   32'd1);
      rst_n = 1'b1;

      // Single word, one-cycle valid pulse, two-cycle latency.
      @(negedge clk);
      therm_in = 32'h0000_00FF;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      chk("single_early_valid", 32'(out_valid), 32'd0);
      @(negedge clk);
      chk("single_valid", 32'(out_valid),  32'd1);
      chk("single_code",  32'(code_out),   32'd7);
      chk("single_bub",   32'(bubble_err), 32'd0);
      chk("single_zero",  32'(zero_err),   32'd0);
      @(negedge clk);
      chk("single_valid_drop", 32'(out_valid), 32'd0);

      // Back-to-back table stream; output c reflects the vector from c-2.
      for (int c = 0; c < NV + 3; c++) begin
         @(negedge clk);
         if (c < NV) begin
            therm_in = vecs[c].therm;
            in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         #1;
         chk("tbl_in_ready", 32'(in_ready), 32'd1);
         if (c >= 2 && c < NV + 2) begin
            chk($sformatf("tbl%0d_valid", c - 2), 32'(out_valid),  32'd1);
            chk($sformatf("tbl%0d_code",  c - 2), 32'(code_out),   32'(vecs[c-2].code));
            chk($sformatf("tbl%0d_bub",   c - 2), 32'(bubble_err), 32'(vecs[c-2].bub));
            chk($sformatf("tbl%0d_zero",  c - 2), 32'(zero_err),   32'(vecs[c-2].zero));
         end else if (c == NV + 2) begin
            chk("tbl_valid_drop", 32'(out_valid), 32'd0);
         end
      end

      // Backpressure: A in output slot, B in stage 1, C waiting at input.
      got.delete();
      mon_en = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      therm_in  = 32'h0000_0003;
      in_valid  = 1'b1;
      @(negedge clk);
      therm_in  = 32'h0000_003F;
      @(negedge clk);
      therm_in  = 32'h0000_03FF;
      #1;
      chk("stall_in_ready0", 32'(in_ready), 32'd0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         #1;
         chk($sformatf("stall%0d_valid", k), 32'(out_valid), 32'd1);
         chk($sformatf("stall%0d_code",  k), 32'(code_out),  32'd1);
         chk($sformatf("stall%0d_ready", k), 32'(in_ready),  32'd0);
      end
      @(negedge clk);
      out_ready = 1'b1;
      accepted  = 1'b0;
      for (int k = 0; k < 8 && !accepted; k++) begin
         #1;
         if (in_ready) accepted = 1'b1;
         @(negedge clk);
      end
      in_valid = 1'b0;
      chk("stall_c_accepted", 32'(accepted), 32'd1);
      repeat (6) @(negedge clk);
      #2;
      mon_en = 1'b0;
      chk("stall_count", 32'(got.size()), 32'd3);
      if (got.size() == 3) begin
         chk("stall_order0", 32'(got[0]), 32'd1);
         chk("stall_order1", 32'(got[1]), 32'd5);
         chk("stall_order2", 32'(got[2]), 32'd9);
      end

      // Reset with one word in stage 1: it must never emerge.
      @(negedge clk);
      therm_in = 32'h0000_00FF;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      rst_n    = 1'b0;
      @(negedge clk);
      rst_n    = 1'b1;
      chk("midrst_valid", 32'(out_valid), 32'd0);
      chk("midrst_code",  32'(code_out),  32'd0);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk($sformatf("midrst%0d_no_out", k), 32'(out_valid), 32'd0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
